pipe_reg_file: RTL and testbench

//  Parametrised multi-port register file for the 5-stage pipeline, successor to the 32x32 2R1W file.

---
 rtl/pipe_reg_file.sv | 82 ++++++++
 tb/tb_pipe_reg_file.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_file.sv
// rtl/pipe_reg_file.sv - multi-port register file with write bypass and pending-write scoreboard
// NUM_RD combinational read ports, two write ports, one busy bit per register for the hazard unit.
module pipe_reg_file #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD*DW-1:0] o_rd_data,
  output logic [NUM_RD-1:0]    o_rd_busy,
  input  logic [1:0]           i_wr_en,
  input  logic [2*AW-1:0]      i_wr_addr,
  input  logic [2*DW-1:0]      i_wr_data,
  input  logic                 i_set_en,
  input  logic [AW-1:0]        i_set_addr,
  output logic [DEPTH-1:0]     o_busy_vec
);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [AW-1:0]    w_wa [2];
  logic [DW-1:0]    w_wd [2];
  logic [1:0]       w_wr_ok;

  for (genvar j = 0; j < 2; j++) begin : g_wr
    assign w_wa[j]    = i_wr_addr[j*AW +: AW];
    assign w_wd[j]    = i_wr_data[j*DW +: DW];
    assign w_wr_ok[j] = i_wr_en[j] && !((ZERO_REG != 0) && (w_wa[j] == '0));
  end

  // A new producer issued in the same cycle as the old one retires keeps the register busy.
  always_comb begin
    w_busy_next = r_busy;
    for (int j = 0; j < 2; j++) begin
      if (i_wr_en[j]) w_busy_next[w_wa[j]] = 1'b0;
    end
    if (i_set_en) w_busy_next[i_set_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_busy <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (w_wr_ok[j]) r_mem[w_wa[j]] <= w_wd[j];
      end
      r_busy <= w_busy_next;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit0;
    logic          w_hit1;
    logic [DW-1:0] w_rdata;

    assign w_ra   = i_rd_addr[g*AW +: AW];
    assign w_hit0 = i_wr_en[0] && (w_wa[0] == w_ra);
    assign w_hit1 = i_wr_en[1] && (w_wa[1] == w_ra);

    // Port 1 has bypass priority, mirroring its priority on the storage write.
    always_comb begin
      w_rdata = r_mem[w_ra];
      if (w_hit0) w_rdata = w_wd[0];
      if (w_hit1) w_rdata = w_wd[1];
      if ((ZERO_REG != 0) && (w_ra == '0)) w_rdata = '0;
    end

    assign o_rd_data[g*DW +: DW] = w_rdata;
    assign o_rd_busy[g]          = r_busy[w_ra] & ~(w_hit0 | w_hit1);
  end

  assign o_busy_vec = r_busy;

endmodule

// File: tb/tb_pipe_reg_file.sv
// tb/tb_pipe_reg_file.sv - bench for pipe_reg_file against an array-based register/scoreboard model
module tb_pipe_reg_file;
  localparam int DW = 32, DEPTH = 32, AW = 5, NUM_RD = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic [1:0]           wr_en;
  logic [2*AW-1:0]      wr_addr;
  logic [2*DW-1:0]      wr_data;
  logic                 set_en;
  logic [AW-1:0]        set_addr;
  logic [DEPTH-1:0]     busy_vec;

  logic [DW-1:0]    m_reg [DEPTH];
  logic [DEPTH-1:0] m_busy;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_reg_file #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_set_en(set_en),
    .i_set_addr(set_addr), .o_busy_vec(busy_vec)
  );

  function automatic logic [AW-1:0] wa(int j);
    return wr_addr[j*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] ra(int i);
    return rd_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] rdat(int i);
    return rd_data[i*DW +: DW];
  endfunction

  // Reference read: register 0 is hard zero, then newest write, then stored value.
  function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en[1] && wa(1) == a) return wr_data[DW +: DW];
    if (wr_en[0] && wa(0) == a) return wr_data[0 +: DW];
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    if ((wr_en[0] && wa(0) == a) || (wr_en[1] && wa(1) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic drive(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1, input logic se,
                       input logic [AW-1:0] sa, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    set_en   = se;
    set_addr = sa;
    rd_addr  = {ra1, ra0};
    #1;
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_reg[k] = '0;
      m_busy = '0;
    end else begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wa(j) != 0) m_reg[wa(j)] = wr_data[j*DW +: DW];
      for (int j = 0; j < 2; j++)
        if (wr_en[j]) m_busy[wa(j)] = 1'b0;
      if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 5'd3, 5'd4, 32'h1234, 32'h5678, 1'b1, 5'd8, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, AW'(a), AW'(DEPTH - 1 - a));
      n_cmp++;
      if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
        n_err++;
        $display("FAIL reset addr %0d: data %h busy %b vec %h, want 0", a, rd_data, rd_busy, busy_vec);
      end
    end
  endtask

  task automatic test_write_read();
    drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd5, 5'd0);
    n_cmp++;
    if (rdat(0) !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_read: got %h want deadbeef", rdat(0));
    end
  endtask

  task automatic test_bypass();
    drive(2'b01, 5'd7, 5'd0, 32'h11, '0, 1'b0, 5'd0, 5'd0, 5'd7);
    n_cmp++;
    if (rdat(1) !== 32'h11) begin
      n_err++;
      $display("FAIL bypass: got %h want 00000011", rdat(1));
    end
    tick();
  endtask

  task automatic test_dual_write();
    drive(2'b11, 5'd9, 5'd9, 32'hAAAA, 32'h5555, 1'b0, 5'd0, 5'd9, 5'd0);
    n_cmp++;
    if (rdat(0) !== 32'h5555) begin
      n_err++;
      $display("FAIL dual_write_bypass: got %h want 00005555", rdat(0));
    end
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd9, 5'd9);
    n_cmp++;
    if (rdat(0) !== 32'h5555 || rdat(1) !== 32'h5555) begin
      n_err++;
      $display("FAIL dual_write_stored: got %h/%h want 00005555", rdat(0), rdat(1));
    end
  endtask

  task automatic test_scoreboard();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd3, 5'd3);
    n_cmp++;
    if (rd_busy !== 2'b11 || busy_vec[3] !== 1'b1) begin
      n_err++;
      $display("FAIL sb_set: rd_busy %b vec3 %b want 11/1", rd_busy, busy_vec[3]);
    end
    drive(2'b01, 5'd3, 5'd0, 32'h42, '0, 1'b0, 5'd0, 5'd3, 5'd3);
    n_cmp++;
    if (rd_busy !== 2'b00 || rdat(0) !== 32'h42) begin
      n_err++;
      $display("FAIL sb_release: rd_busy %b data %h want 00/42", rd_busy, rdat(0));
    end
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd3, 5'd3);
    n_cmp++;
    if (busy_vec[3] !== 1'b0) begin
      n_err++;
      $display("FAIL sb_cleared: vec3 %b want 0", busy_vec[3]);
    end
    drive(2'b10, 5'd0, 5'd3, '0, 32'h77, 1'b1, 5'd3, 5'd3, 5'd3);
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd3, 5'd3);
    n_cmp++;
    if (busy_vec[3] !== 1'b1 || rdat(0) !== 32'h77) begin
      n_err++;
      $display("FAIL sb_set_wins: vec3 %b data %h want 1/77", busy_vec[3], rdat(0));
    end
  endtask

  task automatic test_zero_reg();
    drive(2'b01, 5'd0, 5'd0, 32'hFFFF, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    n_cmp++;
    if (rdat(0) !== '0) begin
      n_err++;
      $display("FAIL zero_bypass: got %h want 0", rdat(0));
    end
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    n_cmp++;
    if (rdat(0) !== '0 || busy_vec[0] !== 1'b0 || rd_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zero_reg: data %h vec0 %b busy %b want 0", rdat(0), busy_vec[0], rd_busy[0]);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b1, 5'd6, 5'd4, 5'd6);
    tick();
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd4, 5'd6);
    n_cmp++;
    if (busy_vec[4] !== 1'b1 || busy_vec[6] !== 1'b1 || rd_busy !== 2'b11) begin
      n_err++;
      $display("FAIL stall_setup: vec %h rd_busy %b want bits 4,6 set", busy_vec, rd_busy);
    end
    rst = 1'b1;
    drive(2'b01, 5'd4, 5'd0, 32'h99, '0, 1'b1, 5'd6, 5'd4, 5'd6);
    tick();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a += 2) begin
      drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, AW'(a), AW'(a + 1));
      n_cmp++;
      if (rd_data !== '0 || busy_vec !== '0 || rd_busy !== '0) begin
        n_err++;
        $display("FAIL stall_reset addr %0d: data %h vec %h busy %b want 0", a, rd_data, busy_vec, rd_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(2'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom, $urandom,
            1'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      for (int i = 0; i < NUM_RD; i++) begin
        n_cmp++;
        if (rdat(i) !== exp_data(ra(i)) || rd_busy[i] !== exp_busy(ra(i))) begin
          n_err++;
          $display("FAIL rand_read cyc %0d port %0d addr %0d: data %h busy %b want %h %b",
                   c, i, ra(i), rdat(i), rd_busy[i], exp_data(ra(i)), exp_busy(ra(i)));
        end
      end
      n_cmp++;
      if (busy_vec !== m_busy) begin
        n_err++;
        $display("FAIL rand_busy_vec cyc %0d: got %h want %h", c, busy_vec, m_busy);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
